// File: rtl/shadowmask_loader_if.sv
// Pattern-memory read port between shadowmask_loader and its pattern store.
//   mem_addr : word address, held stable while mem_rd is high
//   mem_rd   : read request, held until mem_ack
//   mem_data : read data, valid in the mem_ack cycle
//   mem_ack  : one-cycle read completion
// master = loader side, slave = memory side.
interface shadowmask_loader_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_data;
  logic              mem_ack;

  modport master (output mem_addr, mem_rd, input  mem_data, mem_ack);
  modport slave  (input  mem_addr, mem_rd, output mem_data, mem_ack);
endinterface

// File: rtl/shadowmask_loader.sv
// Command sequencer feeding the shadowmask stage (clk_sys domain).
// On load it blanks the mask, reads the selected pattern header and 64 LUT
// entries from pattern memory, emits vmax/hmax/LUT commands and finally the
// control word, so a half-loaded pattern is never displayed.
// Ports:
//   clk_sys, reset_n          : clock, async active-low reset
//   load, mask_sel, mask_*    : load request and sampled pattern/mode bits
//   mem (master)              : pattern memory read port
//   cmd_wr, cmd_in            : one-cycle command strobe and held command word
//   busy                      : sequence in progress
//   hdr_err                   : sticky, last header had a field clamped to 7
module shadowmask_loader #(
  parameter int SEL_W  = 3,
  parameter int ADDR_W = SEL_W + 7
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                load,
  input  logic [SEL_W-1:0]    mask_sel,
  input  logic                mask_enable,
  input  logic                mask_2x,
  input  logic                mask_rotate,
  shadowmask_loader_if.master mem,
  output logic                cmd_wr,
  output logic [15:0]         cmd_in,
  output logic                busy,
  output logic                hdr_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BLANK  = 3'd1;
  localparam logic [2:0] S_RD_HDR = 3'd2;
  localparam logic [2:0] S_W_V    = 3'd3;
  localparam logic [2:0] S_W_H    = 3'd4;
  localparam logic [2:0] S_RD_LUT = 3'd5;
  localparam logic [2:0] S_W_LUT  = 3'd6;
  localparam logic [2:0] S_W_CTRL = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d, p_sel_q, p_sel_d;
  logic              en_q, en_d, x2_q, x2_d, rot_q, rot_d;
  logic              p_en_q, p_en_d, p_x2_q, p_x2_d, p_rot_q, p_rot_d;
  logic              pend_q, pend_d;
  logic [5:0]        idx_q, idx_d;
  logic [3:0]        hmax_q, hmax_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [15:0]       cmd_in_q, cmd_in_d;
  logic              busy_q, busy_d;
  logic              hdr_err_q, hdr_err_d;
  logic              unused_data;

  assign unused_data = ^mem.mem_data[15:8];

  function automatic logic [15:0] ctrl_w(input logic en, input logic x2, input logic rot);
    return {13'b0, rot, x2, en};
  endfunction

  function automatic logic [3:0] clamp4(input logic [3:0] f);
    return f[3] ? 4'd7 : f;
  endfunction

  // The command word/strobe is computed for the state being entered, so the
  // strobe is high exactly during the cycle the FSM sits in a write state.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    en_d       = en_q;
    x2_d       = x2_q;
    rot_d      = rot_q;
    p_sel_d    = p_sel_q;
    p_en_d     = p_en_q;
    p_x2_d     = p_x2_q;
    p_rot_d    = p_rot_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    hmax_d     = hmax_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    cmd_wr_d   = 1'b0;
    cmd_in_d   = cmd_in_q;
    busy_d     = busy_q;
    hdr_err_d  = hdr_err_q;

    // Loads during a sequence are parked; the latest one wins.
    if (load && state_q != S_IDLE) begin
      pend_d  = 1'b1;
      p_sel_d = mask_sel;
      p_en_d  = mask_enable;
      p_x2_d  = mask_2x;
      p_rot_d = mask_rotate;
    end

    case (state_q)
      S_IDLE: if (load || pend_q) begin
        if (load) begin
          sel_d = mask_sel;  en_d = mask_enable;  x2_d = mask_2x;  rot_d = mask_rotate;
        end else begin
          sel_d = p_sel_q;   en_d = p_en_q;       x2_d = p_x2_q;   rot_d = p_rot_q;
        end
        pend_d    = 1'b0;
        hdr_err_d = 1'b0;
        busy_d    = 1'b1;
        idx_d     = 6'd0;
        state_d   = S_BLANK;
        cmd_wr_d  = 1'b1;
        cmd_in_d  = ctrl_w(1'b0, x2_d, rot_d);
      end
      S_BLANK: if (en_q) begin
        state_d    = S_RD_HDR;
        mem_rd_d   = 1'b1;
        mem_addr_d = ADDR_W'({sel_q, 7'd0});
      end else begin
        state_d  = S_W_CTRL;
        cmd_wr_d = 1'b1;
        cmd_in_d = ctrl_w(en_q, x2_q, rot_q);
      end
      S_RD_HDR: if (mem.mem_ack && mem_rd_q) begin
        mem_rd_d  = 1'b0;
        hmax_d    = mem.mem_data[7:4];
        state_d   = S_W_V;
        cmd_wr_d  = 1'b1;
        cmd_in_d  = {3'b001, 9'b0, clamp4(mem.mem_data[3:0])};
        hdr_err_d = hdr_err_q | mem.mem_data[3];
      end
      S_W_V: begin
        state_d   = S_W_H;
        cmd_wr_d  = 1'b1;
        cmd_in_d  = {3'b010, 9'b0, clamp4(hmax_q)};
        hdr_err_d = hdr_err_q | hmax_q[3];
      end
      S_W_H: begin
        state_d    = S_RD_LUT;
        mem_rd_d   = 1'b1;
        mem_addr_d = ADDR_W'({sel_q, 7'd1});
      end
      S_RD_LUT: if (mem.mem_ack && mem_rd_q) begin
        mem_rd_d = 1'b0;
        state_d  = S_W_LUT;
        cmd_wr_d = 1'b1;
        cmd_in_d = {3'b011, 3'b000, idx_q, 1'b0, mem.mem_data[2:0]};
      end
      S_W_LUT: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd63) begin
          state_d  = S_W_CTRL;
          cmd_wr_d = 1'b1;
          cmd_in_d = ctrl_w(en_q, x2_q, rot_q);
        end else begin
          state_d    = S_RD_LUT;
          mem_rd_d   = 1'b1;
          mem_addr_d = ADDR_W'({sel_q, {1'b0, idx_q} + 7'd2});
        end
      end
      S_W_CTRL: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      en_q       <= 1'b0;
      x2_q       <= 1'b0;
      rot_q      <= 1'b0;
      p_sel_q    <= '0;
      p_en_q     <= 1'b0;
      p_x2_q     <= 1'b0;
      p_rot_q    <= 1'b0;
      pend_q     <= 1'b0;
      idx_q      <= 6'd0;
      hmax_q     <= 4'd0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      cmd_wr_q   <= 1'b0;
      cmd_in_q   <= 16'd0;
      busy_q     <= 1'b0;
      hdr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      x2_q       <= x2_d;
      rot_q      <= rot_d;
      p_sel_q    <= p_sel_d;
      p_en_q     <= p_en_d;
      p_x2_q     <= p_x2_d;
      p_rot_q    <= p_rot_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      hmax_q     <= hmax_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_in_q   <= cmd_in_d;
      busy_q     <= busy_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd_q;
  assign cmd_wr       = cmd_wr_q;
  assign cmd_in       = cmd_in_q;
  assign busy         = busy_q;
  assign hdr_err      = hdr_err_q;

endmodule

// File: tb/tb_shadowmask_loader.sv
module tb_shadowmask_loader;
  localparam int SEL_W  = 3;
  localparam int ADDR_W = 10;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic load = 1'b0;
  logic [SEL_W-1:0] mask_sel = '0;
  logic mask_enable = 1'b0, mask_2x = 1'b0, mask_rotate = 1'b0;
  logic cmd_wr, busy, hdr_err;
  logic [15:0] cmd_in;

  shadowmask_loader_if #(.ADDR_W(ADDR_W)) mif();

  shadowmask_loader #(.SEL_W(SEL_W), .ADDR_W(ADDR_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .load(load), .mask_sel(mask_sel),
    .mask_enable(mask_enable), .mask_2x(mask_2x), .mask_rotate(mask_rotate),
    .mem(mif), .cmd_wr(cmd_wr), .cmd_in(cmd_in), .busy(busy), .hdr_err(hdr_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, failures = 0;
  int cyc = 0, load_cyc = 0;
  int lat = 1;
  bit spur = 1'b0;
  bit exp_err;
  logic [15:0] mem [0:1023];
  logic [15:0] exp_q[$], got_cmd[$];
  int got_cyc[$];
  logic [ADDR_W-1:0] rd_addr[$];
  logic [ADDR_W-1:0] resp_addr;
  logic rd_prev = 1'b0;
  bit aborted;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Strobe / read-start monitor
  always @(negedge clk_sys) begin
    if (cmd_wr) begin
      got_cmd.push_back(cmd_in);
      got_cyc.push_back(cyc);
    end
    if (mif.mem_rd && !rd_prev) rd_addr.push_back(mif.mem_addr);
    rd_prev <= mif.mem_rd;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Pattern memory: acks `lat` cycles after seeing mem_rd, checks the request holds meanwhile
  initial begin
    mif.mem_ack  = 1'b0;
    mif.mem_data = 16'd0;
    forever begin
      @(posedge clk_sys); #1;
      mif.mem_ack = 1'b0;
      if (reset_n && mif.mem_rd === 1'b1) begin
        resp_addr = mif.mem_addr;
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk_sys); #1;
          if (!reset_n) begin aborted = 1'b1; break; end
          chk("rd_hold", {21'b0, mif.mem_rd, mif.mem_addr}, {21'b0, 1'b1, resp_addr});
        end
        if (!aborted) begin
          mif.mem_data = mem[resp_addr];
          mif.mem_ack  = 1'b1;
        end
      end else if (spur && reset_n && $urandom_range(0, 3) == 0) begin
        mif.mem_data = 16'($urandom);
        mif.mem_ack  = 1'b1;
      end
    end
  end

  // Reference: expected command list straight from the pattern layout
  task automatic model(input int sel, input bit en, input bit x2, input bit rot);
    int base = sel * 128;
    int v = int'(mem[base] & 16'h000F);
    int h = int'((mem[base] >> 4) & 16'h000F);
    exp_q.push_back({13'b0, rot, x2, 1'b0});
    if (en) begin
      exp_q.push_back(16'h2000 | 16'(v > 7 ? 7 : v));
      exp_q.push_back(16'h4000 | 16'(h > 7 ? 7 : h));
      for (int i = 0; i < 64; i++)
        exp_q.push_back(16'h6000 | 16'(i * 16) | (mem[base + 1 + i] & 16'h0007));
    end
    exp_q.push_back({13'b0, rot, x2, en});
    exp_err = en && (v > 7 || h > 7);
  endtask

  task automatic fill(input int sel, input logic [15:0] hdr, input bit mod8);
    mem[sel * 128] = hdr;
    for (int i = 0; i < 64; i++)
      mem[sel * 128 + 1 + i] = mod8 ? ((16'($urandom) & 16'hFFF8) | 16'(i % 8)) : 16'($urandom);
  endtask

  task automatic clear();
    exp_q.delete(); got_cmd.delete(); got_cyc.delete(); rd_addr.delete();
  endtask

  task automatic do_load(input int sel, input bit en, input bit x2, input bit rot);
    @(negedge clk_sys);
    mask_sel = SEL_W'(sel); mask_enable = en; mask_2x = x2; mask_rotate = rot;
    load = 1'b1; load_cyc = cyc;
    @(negedge clk_sys);
    load = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while ((got_cmd.size() < n || busy) && k < budget) begin
      @(negedge clk_sys); #1; k++;
    end
    chk({tag, "_done"}, {busy, 31'(got_cmd.size())}, {1'b0, 31'(n)});
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_count"}, 32'(got_cmd.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_cmd.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), 32'(got_cmd[i]), 32'(exp_q[i]));
  endtask

  function automatic int gcyc(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1;
  endfunction

  function automatic logic [ADDR_W-1:0] raddr(input int i);
    return (i < rd_addr.size()) ? rd_addr[i] : 'x;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, k, n;
    bit en, x2, rot;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

    // Reset values
    repeat (3) @(negedge clk_sys);
    chk("rst_cmd_wr", 32'(cmd_wr), 0);
    chk("rst_cmd_in", 32'(cmd_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hdr_err", 32'(hdr_err), 0);
    chk("rst_mem_rd", 32'(mif.mem_rd), 0);
    chk("rst_mem_addr", 32'(mif.mem_addr), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // A: basic enabled load, sel=2
    fill(2, 16'h0035, 1'b1);
    clear(); lat = 1;
    do_load(2, 1, 0, 0); model(2, 1, 0, 0);
    wait_done(68, 400, "A");
    cmp_seq("A");
    chk("A_first_addr", 32'(raddr(0)), 32'h100);
    chk("A_reads", 32'(rd_addr.size()), 65);
    chk("A_blank_cyc", 32'(gcyc(0) - load_cyc), 1);
    chk("A_ctrl_cyc", 32'(gcyc(67) - load_cyc), 198);
    chk("A_hdr_err", 32'(hdr_err), 0);

    // B: disabled mask
    clear();
    do_load(5, 0, 1, 1); model(5, 0, 1, 1);
    wait_done(2, 50, "B");
    cmp_seq("B");
    chk("B_cyc0", 32'(gcyc(0) - load_cyc), 1);
    chk("B_cyc1", 32'(gcyc(1) - load_cyc), 2);
    chk("B_no_rd", 32'(rd_addr.size()), 0);

    // C: clamped header, then a clean one clears hdr_err
    fill(4, 16'h00F9, 1'b0);
    clear();
    do_load(4, 1, 1, 0); model(4, 1, 1, 0);
    wait_done(68, 400, "C");
    cmp_seq("C");
    chk("C_hdr_err", 32'(hdr_err), 32'(exp_err));
    clear();
    do_load(2, 1, 0, 0); model(2, 1, 0, 0);
    chk("C2_err_cleared_early", 32'(hdr_err), 0);
    wait_done(68, 400, "C2");
    cmp_seq("C2");
    chk("C2_hdr_err", 32'(hdr_err), 0);

    // D: slow memory
    clear(); lat = 5;
    do_load(2, 1, 0, 0); model(2, 1, 0, 0);
    wait_done(68, 2000, "D");
    cmp_seq("D");
    lat = 1;

    // E: loads while busy are queued, last one wins
    fill(1, 16'(($urandom & 16'hFF00) | 16'h0062), 1'b0);
    clear();
    do_load(2, 1, 0, 0);
    k = 0;
    while (got_cmd.size() < 6 && k < 100) begin @(negedge clk_sys); #1; k++; end
    do_load(6, 0, 1, 0);
    k = 0;
    while (got_cmd.size() < 14 && k < 100) begin @(negedge clk_sys); #1; k++; end
    do_load(1, 1, 0, 1);
    model(2, 1, 0, 0); model(1, 1, 0, 1);
    wait_done(136, 1000, "E");
    cmp_seq("E");
    chk("E_gap", 32'(gcyc(68) - gcyc(67)), 2);
    chk("E_second_base", 32'(raddr(65)), 32'h080);

    // F: randomized loads with variable latency and stray acks
    spur = 1'b1;
    for (int t = 0; t < 6; t++) begin
      sel = int'($urandom_range(0, 7));
      en = ($urandom_range(0, 3) != 0); x2 = 1'($urandom); rot = 1'($urandom);
      fill(sel, 16'($urandom), 1'b0);
      lat = int'($urandom_range(1, 4));
      clear();
      do_load(sel, en, x2, rot); model(sel, en, x2, rot);
      wait_done(en ? 68 : 2, 1000, $sformatf("F%0d", t));
      cmp_seq($sformatf("F%0d", t));
      chk($sformatf("F%0d_hdr_err", t), 32'(hdr_err), 32'(exp_err));
    end
    spur = 1'b0; lat = 1;

    // G: reset in the middle of the LUT reads
    fill(3, 16'h0044, 1'b0);
    clear();
    do_load(3, 1, 0, 0);
    k = 0;
    while (got_cmd.size() < 23 && k < 200) begin @(negedge clk_sys); #1; k++; end
    k = 0;
    while (mif.mem_rd !== 1'b1 && k < 20) begin @(negedge clk_sys); #1; k++; end
    chk("G_in_rd", 32'(mif.mem_rd), 1);
    reset_n = 1'b0;
    #1;
    chk("G_cmd_wr", 32'(cmd_wr), 0);
    chk("G_mem_rd", 32'(mif.mem_rd), 0);
    chk("G_busy", 32'(busy), 0);
    chk("G_mem_addr", 32'(mif.mem_addr), 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    n = got_cmd.size();
    repeat (20) @(negedge clk_sys);
    #1;
    chk("G_no_strobes", 32'(got_cmd.size()), 32'(n));
    chk("G_busy_after", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
